// File: rtl/irq_frontend_pkg.sv
// Shared constants for the interrupt front end: register map, MODE encodings,
// bus mode codes and the channel count.
package irq_frontend_pkg;

  localparam int NUM_CH = 4;

  localparam logic [31:0] ADDR_MODE     = 32'h0000_4100;
  localparam logic [31:0] ADDR_DEBOUNCE = 32'h0000_4104;
  localparam logic [31:0] ADDR_STATUS   = 32'h0000_4108;
  localparam logic [31:0] ADDR_COUNT    = 32'h0000_410C;

  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } irq_mode_e;

  function automatic logic edge_match(input irq_mode_e mode, input logic cur, input logic prev);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (mode)
      MODE_RISE: return rise;
      MODE_FALL: return fall;
      MODE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: synchronizer, optional debounce, edge detect,
// registered active-low pulse and saturating event counter.
// Debounce logic is built only when IRQ_FRONTEND_DEBOUNCE_EN is defined.
module irq_channel
  import irq_frontend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_irq,
  input  irq_mode_e  mode,
`ifdef IRQ_FRONTEND_DEBOUNCE_EN
  input  logic [7:0] deb_threshold,
`endif
  input  logic       armed,
  input  logic       clear,
  output logic       stable,
  output logic       irq_n,
  output logic [7:0] count
);

  logic s1;
  logic s2;
  logic prev;
  logic evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ext_irq;
      s2 <= s1;
    end
  end

`ifdef IRQ_FRONTEND_DEBOUNCE_EN
  logic       stable_q;
  logic [7:0] deb_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      deb_cnt  <= 8'd0;
    end else if (s2 == stable_q) begin
      deb_cnt <= 8'd0;
    end else if (deb_cnt + 8'd1 >= deb_threshold) begin
      stable_q <= s2;
      deb_cnt  <= 8'd0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  // A zero threshold bypasses the register so latency matches the no-debounce build.
  assign stable = (deb_threshold == 8'd0) ? s2 : stable_q;
`else
  assign stable = s2;
`endif

  assign evt = armed & edge_match(mode, stable, prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      irq_n <= 1'b1;
    end else begin
      prev  <= stable;
      irq_n <= ~evt;
    end
  end

  // Clear has priority over a same-cycle increment; the pulse itself is unaffected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (evt && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/irq_frontend.sv
// Interrupt front end top: bus register decode, arming window and four irq_channel
// instances. Define IRQ_FRONTEND_DEBOUNCE_EN to include the DEBOUNCE register.
module irq_frontend
  import irq_frontend_pkg::*;
#(
  parameter logic [7:0] DEB_RESET = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ext_irq,
  output logic [3:0]  irq_n,
  input  logic [31:0] slv_address,
  input  logic [31:0] slv_write_data,
  input  logic [1:0]  slv_mode,
  input  logic        slv_select,
  output logic [31:0] slv_read_data
);

  logic [7:0]        mode_reg;
  logic [1:0]        arm_cnt;
  logic              armed;
  logic              wr_en;
  logic [NUM_CH-1:0] clear_vec;
  logic [NUM_CH-1:0] stable;
  logic [7:0]        count [NUM_CH];
  logic              unused_bits;

  assign wr_en     = slv_select && (slv_mode == BUS_WRITE);
  assign clear_vec = (wr_en && slv_address == ADDR_COUNT) ? slv_write_data[NUM_CH-1:0] : '0;
  assign armed     = (arm_cnt == 2'd3);
  assign unused_bits = ^{slv_write_data[31:8], DEB_RESET};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg <= 8'd0;
    end else if (wr_en && slv_address == ADDR_MODE) begin
      mode_reg <= slv_write_data[7:0];
    end
  end

  // Holds events off for three cycles after reset while prev tracks the live level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= 2'd0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

`ifdef IRQ_FRONTEND_DEBOUNCE_EN
  logic [7:0] deb_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_reg <= DEB_RESET;
    end else if (wr_en && slv_address == ADDR_DEBOUNCE) begin
      deb_reg <= slv_write_data[7:0];
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    irq_channel u_ch (
      .clk          (clk),
      .reset        (reset),
      .ext_irq      (ext_irq[i]),
      .mode         (irq_mode_e'(mode_reg[2*i +: 2])),
`ifdef IRQ_FRONTEND_DEBOUNCE_EN
      .deb_threshold(deb_reg),
`endif
      .armed        (armed),
      .clear        (clear_vec[i]),
      .stable       (stable[i]),
      .irq_n        (irq_n[i]),
      .count        (count[i])
    );
  end

  always_comb begin
    slv_read_data = 32'd0;
    if (slv_select && slv_mode == BUS_READ) begin
      case (slv_address)
        ADDR_MODE:     slv_read_data = {24'd0, mode_reg};
`ifdef IRQ_FRONTEND_DEBOUNCE_EN
        ADDR_DEBOUNCE: slv_read_data = {24'd0, deb_reg};
`endif
        ADDR_STATUS:   slv_read_data = {28'd0, stable};
        ADDR_COUNT:    slv_read_data = {count[3], count[2], count[1], count[0]};
        default:       slv_read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_frontend.sv
// Self-checking bench for irq_frontend: register table, directed corner cases and a
// randomized run against a history-based reference model. Works with or without
// IRQ_FRONTEND_DEBOUNCE_EN defined.
module tb_irq_frontend;
  import irq_frontend_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  ext_irq;
  logic [3:0]  irq_n;
  logic [31:0] slv_address;
  logic [31:0] slv_write_data;
  logic [31:0] slv_read_data;
  logic [1:0]  slv_mode;
  logic        slv_select;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_FRONTEND_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  typedef struct {
    logic        sel;
    logic [1:0]  bmode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] expected;
  } reg_vec_t;

  irq_frontend #(.DEB_RESET(8'd4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_irq       (ext_irq),
    .irq_n         (irq_n),
    .slv_address   (slv_address),
    .slv_write_data(slv_write_data),
    .slv_mode      (slv_mode),
    .slv_select    (slv_select),
    .slv_read_data (slv_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic sel, input logic [1:0] bmode,
                                input logic [31:0] addr, input logic [31:0] wdata);
    slv_select     = sel;
    slv_mode       = bmode;
    slv_address    = addr;
    slv_write_data = wdata;
    cycle();
    slv_select     = 1'b0;
    slv_mode       = 2'b00;
    slv_address    = 32'd0;
    slv_write_data = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    slv_select  = 1'b1;
    slv_mode    = BUS_READ;
    slv_address = addr;
    #1;
    data        = slv_read_data;
    slv_select  = 1'b0;
    slv_mode    = 2'b00;
    slv_address = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    apply_stimulus(1'b1, BUS_WRITE, addr, wdata);
  endtask

  reg_vec_t    vecs[12];
  logic [31:0] rd;
  logic [7:0]  rand_mode;
  logic [3:0]  hist[$];
  logic [3:0]  exp_irq;
  logic [3:0]  cur;
  logic [3:0]  prv;
  int          exp_cnt[4];
  int          lows;
  logic        e;

  initial begin
    reset = 1'b1;
    ext_irq = 4'h0;
    slv_select = 1'b0;
    slv_mode = 2'b00;
    slv_address = 32'd0;
    slv_write_data = 32'd0;

    // Reset state
    @(negedge clk);
    check_output("reset_irq_n", {28'd0, irq_n}, 32'hF);
    bus_read(ADDR_MODE, rd);     check_output("reset_mode", rd, 32'h0);
    bus_read(ADDR_DEBOUNCE, rd); check_output("reset_deb", rd, DEB_ON ? 32'h4 : 32'h0);
    bus_read(ADDR_STATUS, rd);   check_output("reset_status", rd, 32'h0);
    bus_read(ADDR_COUNT, rd);    check_output("reset_count", rd, 32'h0);
    reset = 1'b0;
    repeat (4) cycle();

    // Register access table
    vecs[0]  = '{1'b1, BUS_WRITE, ADDR_MODE,     32'h0000_00A5, ADDR_MODE,     32'hA5};
    vecs[1]  = '{1'b1, BUS_WRITE, ADDR_MODE,     32'hDEAD_BE12, ADDR_MODE,     32'h12};
    vecs[2]  = '{1'b0, BUS_WRITE, ADDR_MODE,     32'h0000_0077, ADDR_MODE,     32'h12};
    vecs[3]  = '{1'b1, 2'b11,     ADDR_MODE,     32'h0000_0077, ADDR_MODE,     32'h12};
    vecs[4]  = '{1'b1, BUS_READ,  ADDR_MODE,     32'h0000_0077, ADDR_MODE,     32'h12};
    vecs[5]  = '{1'b1, BUS_WRITE, ADDR_STATUS,   32'h0000_000F, ADDR_STATUS,   32'h0};
    vecs[6]  = '{1'b1, BUS_WRITE, 32'h0000_4110, 32'hFFFF_FFFF, 32'h0000_4110, 32'h0};
    vecs[7]  = '{1'b1, BUS_WRITE, ADDR_MODE,     32'h0000_0000, 32'h0000_4000, 32'h0};
    vecs[8]  = '{1'b1, BUS_WRITE, ADDR_DEBOUNCE, 32'h0000_01FF, ADDR_DEBOUNCE, DEB_ON ? 32'hFF : 32'h0};
    vecs[9]  = '{1'b1, BUS_WRITE, ADDR_DEBOUNCE, 32'h0000_0000, ADDR_DEBOUNCE, 32'h0};
    vecs[10] = '{1'b1, BUS_WRITE, ADDR_COUNT,    32'h0000_000F, ADDR_COUNT,    32'h0};
    vecs[11] = '{1'b0, 2'b00,     ADDR_MODE,     32'h0,         32'h0000_4101, 32'h0};
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].sel, vecs[i].bmode, vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].raddr, rd);
      check_output($sformatf("reg_vec[%0d]", i), rd, vecs[i].expected);
    end

    // Rising edge on channel 0: pulse on the third edge, one cycle wide
    bus_write(ADDR_MODE, 32'h01);
    ext_irq[0] = 1'b1;
    cycle(); check_output("lat_edge1", {28'd0, irq_n}, 32'hF);
    cycle(); check_output("lat_edge2", {28'd0, irq_n}, 32'hF);
    cycle(); check_output("lat_edge3", {28'd0, irq_n}, 32'hE);
    cycle(); check_output("lat_edge4", {28'd0, irq_n}, 32'hF);
    bus_read(ADDR_COUNT, rd); check_output("lat_count", rd, 32'h1);

    // 300 rising events saturate channel 1, then clear collides with an event
    bus_write(ADDR_MODE, 32'h04);
    for (int i = 0; i < 600; i++) begin
      ext_irq[1] = i[0];
      cycle();
    end
    ext_irq[1] = 1'b0;
    repeat (5) cycle();
    bus_read(ADDR_COUNT, rd); check_output("sat_count", rd, 32'h0000_FF01);
    ext_irq[1] = 1'b1;
    cycle();
    cycle();
    bus_write(ADDR_COUNT, 32'h2);
    check_output("clr_pulse", {28'd0, irq_n}, 32'hD);
    bus_read(ADDR_COUNT, rd); check_output("clr_count", rd, 32'h1);

    // Back-to-back events on one channel give back-to-back pulses
    ext_irq = 4'h0;
    repeat (5) cycle();
    bus_write(ADDR_MODE, 32'h03);
    ext_irq[0] = 1'b1;
    cycle(); check_output("b2b_e1", {31'd0, irq_n[0]}, 32'h1);
    ext_irq[0] = 1'b0;
    cycle(); check_output("b2b_e2", {31'd0, irq_n[0]}, 32'h1);
    cycle(); check_output("b2b_e3", {31'd0, irq_n[0]}, 32'h0);
    cycle(); check_output("b2b_e4", {31'd0, irq_n[0]}, 32'h0);
    cycle(); check_output("b2b_e5", {31'd0, irq_n[0]}, 32'h1);

    // Randomized run against history model (debounce threshold is 0 here)
    repeat (4) cycle();
    rand_mode = 8'($urandom);
    bus_write(ADDR_MODE, {24'd0, rand_mode});
    bus_write(ADDR_COUNT, 32'hF);
    for (int i = 0; i < 4; i++) hist.push_back(4'h0);
    for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
    for (int i = 0; i < 504; i++) begin
      if (i < 500) ext_irq = 4'($urandom_range(0, 15));
      hist.push_back(ext_irq);
      cycle();
      cur = hist[hist.size()-3];
      prv = hist[hist.size()-4];
      for (int n = 0; n < 4; n++) begin
        e = (rand_mode[2*n] && cur[n] && !prv[n]) || (rand_mode[2*n+1] && !cur[n] && prv[n]);
        exp_irq[n] = ~e;
        if (e && exp_cnt[n] < 255) exp_cnt[n]++;
      end
      check_output($sformatf("rand_irq[%0d]", i), {28'd0, irq_n}, {28'd0, exp_irq});
      bus_read(ADDR_STATUS, rd);
      check_output($sformatf("rand_status[%0d]", i), rd, {28'd0, hist[hist.size()-2]});
    end
    bus_read(ADDR_COUNT, rd);
    check_output("rand_count", rd, {exp_cnt[3][7:0], exp_cnt[2][7:0], exp_cnt[1][7:0], exp_cnt[0][7:0]});

    // Glitch versus long pulse on channel 2 with threshold 4
    ext_irq = 4'h0;
    repeat (6) cycle();
    bus_write(ADDR_DEBOUNCE, 32'h4);
    bus_write(ADDR_MODE, 32'hFF);
    bus_write(ADDR_COUNT, 32'hF);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      ext_irq[2] = (i < 2);
      cycle();
      if (!irq_n[2]) lows++;
    end
    check_output("glitch_pulses", lows, DEB_ON ? 32'd0 : 32'd2);
    bus_read(ADDR_COUNT, rd); check_output("glitch_count", rd, DEB_ON ? 32'h0 : 32'h0002_0000);
    bus_write(ADDR_COUNT, 32'hF);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      ext_irq[2] = (i < 6);
      cycle();
      if (!irq_n[2]) lows++;
    end
    check_output("long_pulses", lows, 32'd2);
    bus_read(ADDR_COUNT, rd); check_output("long_count", rd, 32'h0002_0000);

    // Lines held high through reset release produce no events
    reset = 1'b1;
    ext_irq = 4'hF;
    cycle();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_output($sformatf("held_pre[%0d]", i), {28'd0, irq_n}, 32'hF);
    end
    bus_write(ADDR_MODE, 32'h55);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_output($sformatf("held_post[%0d]", i), {28'd0, irq_n}, 32'hF);
    end

    // Reset mid-pulse releases irq_n asynchronously and restores registers
    bus_write(ADDR_DEBOUNCE, 32'h0);
    bus_write(ADDR_MODE, 32'hFF);
    ext_irq[3] = 1'b0;
    cycle(); check_output("mid_e1", {28'd0, irq_n}, 32'hF);
    cycle(); check_output("mid_e2", {28'd0, irq_n}, 32'hF);
    cycle(); check_output("mid_e3", {28'd0, irq_n}, 32'h7);
    reset = 1'b1;
    #1;
    check_output("mid_async", {28'd0, irq_n}, 32'hF);
    bus_read(ADDR_MODE, rd);     check_output("mid_mode", rd, 32'h0);
    bus_read(ADDR_DEBOUNCE, rd); check_output("mid_deb", rd, DEB_ON ? 32'h4 : 32'h0);
    bus_read(ADDR_STATUS, rd);   check_output("mid_status", rd, 32'h0);
    bus_read(ADDR_COUNT, rd);    check_output("mid_count", rd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
